onn_seq_ctrl: RTL and testbench
===============================

# onn_seq_ctrl

Parametrised sequencing controller for the ONN oscillator array, replacing the fixed 15-oscillator control FSM. It drives the weight-load window, the phase-release/settle/check iteration loop and the final phase-to-output transfer. It adds a bounded iteration count with timeout, an N-consecutive-stable convergence criterion, a popcount of changed oscillators, abort, and a done/ack handshake toward the host interface.

## Interface
- N_OSC, 15, number of oscillators; width of `state_changed`; 1..64.
- LOAD_CYCLES, 60, cycles `full_tick` is held during weight load; ≥1.
- SETTLE_CYCLES, 17, cycles of free oscillation per iteration; ≥1.
- MAX_ITER, 32, iteration limit before timeout; ≥1.
- STABLE_ITERS, 2, consecutive checks with no change required to declare convergence; 1..MAX_ITER.
- sclk  in  1  system clock; all logic on rising edge.
- re_n  in  1  asynchronous active-low reset.
- load  in  1  start request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- done_ack  in  1  host acknowledge; sampled only in DONE.
- state_changed  in  N_OSC  per-oscillator phase-changed flags; sampled only in CHECK.
- full_tick  out  1  weight-load window.
- drop  out  1  one-cycle pulse clearing oscillator phase latches before the first iteration.
- osc_rst  out  1  one-cycle phase-release pulse at the start of each iteration.
- state_check  out  1  one-cycle strobe while `state_changed` is sampled.
- phi_to_no  out  1  phase-to-neuron-output transfer, held in DONE.
- busy  out  1  high in every state except IDLE and DONE.
- timeout  out  1  DONE was reached by hitting MAX_ITER.
- iter_count  out  clog2(MAX_ITER+1)  iterations started in the current run.
- changed_count  out  clog2(N_OSC+1)  popcount of `state_changed` captured at the last CHECK.

## Operation
- States: IDLE, LOAD, INIT, RUN, SETTLE, CHECK, DONE. All outputs are registered Moore decodes. An output is valid in exactly the cycles the FSM occupies its state.
- Reset (re_n=0, any time, including mid-run): state=IDLE. All outputs are 0. `iter_count`, `changed_count`, the stable counter and the cycle counter are 0.
- IDLE: all strobes 0. load=1 -> LOAD.
- LOAD: `full_tick`=1. The cycle counter runs from 0 to LOAD_CYCLES-1. On the last count -> INIT.
- INIT: `drop`=1 for one cycle. Clear `iter_count`, the stable counter and `timeout`. -> RUN.
- RUN: `osc_rst`=1 for one cycle. `iter_count` += 1. -> SETTLE.
- SETTLE: all strobes 0. The counter runs for SETTLE_CYCLES cycles, then -> CHECK.
- CHECK: `state_check`=1. Latch `changed_count` = popcount(`state_changed`).
  - If any bit of `state_changed` is set, stable counter := 0. Otherwise stable counter += 1, saturating.
  - If the post-update stable counter = STABLE_ITERS -> DONE with timeout=0.
  - Otherwise, if `iter_count` = MAX_ITER -> DONE with timeout=1.
  - Otherwise -> RUN.
  - When convergence and the iteration limit occur in the same CHECK, convergence wins (timeout=0).
- DONE: `phi_to_no`=1, `busy`=0. `timeout`, `iter_count` and `changed_count` are held. done_ack=1 -> IDLE.
- Leaving DONE clears `phi_to_no`. `timeout`, `iter_count` and `changed_count` hold until the next INIT.
- abort=1 in any non-IDLE state -> IDLE on the next edge, with all strobes 0 and `timeout`=0. Abort has priority over every other transition, including done_ack.
- `load` outside IDLE is ignored and not queued.
- If done_ack and load are both high in DONE, the FSM goes to IDLE only. `load` must be high again in IDLE to start a new run.

## Timing
- `load` sampled high at edge t puts the FSM in LOAD from cycle t+1 through t+LOAD_CYCLES.
- Cycle t+L+1 (L=LOAD_CYCLES) is INIT; cycle t+L+2 is the first RUN.
- Each iteration takes SETTLE_CYCLES+2 cycles: 1 RUN + SETTLE_CYCLES SETTLE + 1 CHECK.
- DONE is entered the cycle after the deciding CHECK.
- Minimum run from load to DONE = L + 1 + STABLE_ITERS·(S+2) + 1 cycles.
- Worst case = L + 1 + MAX_ITER·(S+2) + 1 cycles.
- `changed_count` updates on the edge that ends CHECK.

## Test plan
- Convergence, defaults: `state_changed`=15'h0005 on checks 1–3, then 0. Required: DONE after check 5, `iter_count`=5, timeout=0, changed_count=0. `full_tick` high for exactly 60 cycles. `drop` high for 1 cycle. `osc_rst` high 5 times, 19 cycles apart.
- Timeout: `state_changed`=15'h7FFF every check. Required: DONE after check 32, timeout=1, iter_count=32, changed_count=15, `phi_to_no`=1 until done_ack.
- Simultaneous: STABLE_ITERS=1, MAX_ITER=4, `state_changed` nonzero for checks 1–3 and 0 on check 4. Required: DONE with timeout=0, iter_count=4.
- Reset mid-run: assert re_n=0 in SETTLE cycle 8 of iteration 3. Required: on the asynchronous reset, state is IDLE and all outputs and counts are 0. After release, a new `load` gives a full 60-cycle `full_tick` window.
- Abort: assert abort in LOAD cycle 30. Required: IDLE next edge, `full_tick`=0, busy=0. Abort asserted in DONE together with done_ack also gives IDLE with timeout cleared.
- Handshake: done_ack and load both high in DONE. Required: IDLE only, no LOAD. `load` held high in IDLE on the next edge starts LOAD; `load` pulsed during SETTLE has no effect.

Source files
------------

// File: rtl/onn_seq_ctrl_if.sv
// Host/array-facing signal bundle of the ONN sequencing controller.
// The master side issues load/abort/done_ack and supplies the per-oscillator
// change flags. The slave side is the controller, which returns the array
// strobes and the run status.
interface onn_seq_ctrl_if #(
    parameter int N_OSC    = 15,
    parameter int MAX_ITER = 32
) ();
    logic                          load;
    logic                          abort;
    logic                          done_ack;
    logic [N_OSC-1:0]              state_changed;

    logic                          full_tick;
    logic                          drop;
    logic                          osc_rst;
    logic                          state_check;
    logic                          phi_to_no;
    logic                          busy;
    logic                          timeout;
    logic [$clog2(MAX_ITER+1)-1:0] iter_count;
    logic [$clog2(N_OSC+1)-1:0]    changed_count;

    modport master (
        output load, abort, done_ack, state_changed,
        input  full_tick, drop, osc_rst, state_check, phi_to_no, busy,
               timeout, iter_count, changed_count
    );

    modport slave (
        input  load, abort, done_ack, state_changed,
        output full_tick, drop, osc_rst, state_check, phi_to_no, busy,
               timeout, iter_count, changed_count
    );
endinterface

// File: rtl/onn_seq_ctrl.sv
// Sequencing controller for the ONN oscillator array.
// Flow: weight-load window, phase-latch drop, then repeated
// release/settle/check iterations until the array has shown no phase change
// for STABLE_ITERS consecutive checks, or MAX_ITER iterations have run.
// Every output is a registered decode of the state being entered, so each
// strobe is high in exactly the cycles the FSM occupies its state.
module onn_seq_ctrl #(
    parameter int N_OSC         = 15,
    parameter int LOAD_CYCLES   = 60,
    parameter int SETTLE_CYCLES = 17,
    parameter int MAX_ITER      = 32,
    parameter int STABLE_ITERS  = 2
) (
    input  logic           sclk,
    input  logic           re_n,
    onn_seq_ctrl_if.slave  bus
);

    localparam int IW      = $clog2(MAX_ITER + 1);
    localparam int CW      = $clog2(N_OSC + 1);
    localparam int SW      = $clog2(STABLE_ITERS + 1);
    localparam int CYC_MAX = (LOAD_CYCLES > SETTLE_CYCLES) ? LOAD_CYCLES : SETTLE_CYCLES;
    localparam int YW      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    localparam logic [YW-1:0] LOAD_LAST   = YW'(LOAD_CYCLES - 1);
    localparam logic [YW-1:0] SETTLE_LAST = YW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] ITER_LIMIT  = IW'(MAX_ITER);
    localparam logic [SW-1:0] STABLE_GOAL = SW'(STABLE_ITERS);

    // Reject parameter sets the counters cannot represent.
    generate
        if (N_OSC < 1 || N_OSC > 64) begin : g_bad_nosc
            $error("onn_seq_ctrl: N_OSC must be 1..64");
        end
        if (LOAD_CYCLES < 1 || SETTLE_CYCLES < 1 || MAX_ITER < 1) begin : g_bad_len
            $error("onn_seq_ctrl: LOAD_CYCLES, SETTLE_CYCLES and MAX_ITER must be >= 1");
        end
        if (STABLE_ITERS < 1 || STABLE_ITERS > MAX_ITER) begin : g_bad_stable
            $error("onn_seq_ctrl: STABLE_ITERS must be 1..MAX_ITER");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_RUN,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state;
    state_t         nxt_state;
    logic [YW-1:0]  cyc_cnt;
    logic [SW-1:0]  stable_cnt;
    logic [SW-1:0]  stable_nxt;
    logic [CW-1:0]  pop_now;
    logic           any_change;
    logic           converged;
    logic           at_limit;
    logic           abort_hit;

    // Number of oscillators whose phase moved during the last settle window.
    function automatic logic [CW-1:0] popcount(input logic [N_OSC-1:0] v);
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_OSC; i++) begin
            acc = acc + CW'(v[i]);
        end
        return acc;
    endfunction

    // Consecutive-quiet-check counter: any change restarts it, otherwise it
    // climbs and parks at the goal so it can never wrap.
    function automatic logic [SW-1:0] stable_step(input logic [SW-1:0] cnt,
                                                  input logic          changed);
        if (changed) begin
            return '0;
        end
        if (cnt == STABLE_GOAL) begin
            return cnt;
        end
        return cnt + SW'(1);
    endfunction

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        any_change = |bus.state_changed;
        pop_now    = popcount(bus.state_changed);
        stable_nxt = stable_step(stable_cnt, any_change);
        converged  = (stable_nxt == STABLE_GOAL);
        at_limit   = (bus.iter_count == ITER_LIMIT);
        abort_hit  = bus.abort && (state != S_IDLE);
        nxt_state  = state;
        if (abort_hit) begin
            nxt_state = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (bus.load) nxt_state = S_LOAD;
                S_LOAD:   if (cyc_cnt == LOAD_LAST) nxt_state = S_INIT;
                S_INIT:   nxt_state = S_RUN;
                S_RUN:    nxt_state = S_SETTLE;
                S_SETTLE: if (cyc_cnt == SETTLE_LAST) nxt_state = S_CHECK;
                S_CHECK:  nxt_state = (converged || at_limit) ? S_DONE : S_RUN;
                S_DONE:   if (bus.done_ack) nxt_state = S_IDLE;
                default:  nxt_state = S_IDLE;
            endcase
        end
    end

    // State register, window counter, run status and registered output decode.
    always_ff @(posedge sclk or negedge re_n) begin
        if (!re_n) begin
            state             <= S_IDLE;
            cyc_cnt           <= '0;
            stable_cnt        <= '0;
            bus.iter_count    <= '0;
            bus.changed_count <= '0;
            bus.timeout       <= 1'b0;
            bus.full_tick     <= 1'b0;
            bus.drop          <= 1'b0;
            bus.osc_rst       <= 1'b0;
            bus.state_check   <= 1'b0;
            bus.phi_to_no     <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            state <= nxt_state;

            // The window counter restarts on every state change and only
            // advances while dwelling in LOAD or SETTLE.
            if ((nxt_state == state) && (state == S_LOAD || state == S_SETTLE)) begin
                cyc_cnt <= cyc_cnt + YW'(1);
            end else begin
                cyc_cnt <= '0;
            end

            if (nxt_state == S_INIT) begin
                bus.iter_count <= '0;
                stable_cnt     <= '0;
            end else if (nxt_state == S_RUN) begin
                bus.iter_count <= bus.iter_count + IW'(1);
            end

            if (state == S_CHECK && !abort_hit) begin
                stable_cnt        <= stable_nxt;
                bus.changed_count <= pop_now;
            end

            // Convergence takes precedence when it coincides with the limit.
            if (abort_hit || nxt_state == S_INIT) begin
                bus.timeout <= 1'b0;
            end else if (state == S_CHECK && nxt_state == S_DONE) begin
                bus.timeout <= !converged;
            end

            bus.full_tick   <= (nxt_state == S_LOAD);
            bus.drop        <= (nxt_state == S_INIT);
            bus.osc_rst     <= (nxt_state == S_RUN);
            bus.state_check <= (nxt_state == S_CHECK);
            bus.phi_to_no   <= (nxt_state == S_DONE);
            bus.busy        <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
        end
    end

endmodule

// File: tb/tb_onn_seq_ctrl.sv
// Bench for onn_seq_ctrl. The stimulus tasks walk each run cycle by cycle
// using the published timing rules (L load cycles, one drop, S+2 cycles per
// iteration, DONE until acknowledge) and record what every output must be;
// one negedge process compares the DUT against that record. A second
// instance with STABLE_ITERS=1, MAX_ITER=4 covers the coincident
// convergence/limit case.
module tb_onn_seq_ctrl;
    localparam int NO  = 15;
    localparam int LC  = 60;
    localparam int SC  = 17;
    localparam int MI  = 32;
    localparam int SI  = 2;
    localparam int IWA = $clog2(MI + 1);
    localparam int CWA = $clog2(NO + 1);

    logic sclk = 1'b0;
    logic re_n = 1'b0;
    always #5 sclk = ~sclk;

    onn_seq_ctrl_if #(.N_OSC(NO), .MAX_ITER(MI)) ba ();
    onn_seq_ctrl_if #(.N_OSC(NO), .MAX_ITER(4))  bb ();

    onn_seq_ctrl #(.N_OSC(NO), .LOAD_CYCLES(LC), .SETTLE_CYCLES(SC),
                   .MAX_ITER(MI), .STABLE_ITERS(SI)) dut_a (
        .sclk(sclk), .re_n(re_n), .bus(ba));

    onn_seq_ctrl #(.N_OSC(NO), .LOAD_CYCLES(3), .SETTLE_CYCLES(2),
                   .MAX_ITER(4), .STABLE_ITERS(1)) dut_b (
        .sclk(sclk), .re_n(re_n), .bus(bb));

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Expected outputs of dut_a for the current cycle.
    logic exp_on = 1'b0;
    logic e_ft, e_dr, e_or, e_sc, e_phi, e_busy;
    logic m_timeout = 1'b0;
    int   m_iter    = 0;
    int   m_chg     = 0;
    int   m_stable  = 0;

    // Per-run tallies of dut_a strobes.
    int ft_cnt, drop_cnt, orst_cnt, orst_last, gap_min, gap_max;

    logic [NO-1:0] pats [0:39];
    int            npat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 'h%0h, required 'h%0h", name, cyc, act, req);
        end
    endtask

    task automatic set_exp(input logic ft, input logic dr, input logic orr,
                           input logic sc, input logic phi, input logic bz);
        e_ft = ft; e_dr = dr; e_or = orr; e_sc = sc; e_phi = phi; e_busy = bz;
        exp_on = 1'b1;
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
        cyc++;
        ft_cnt   += int'(ba.full_tick);
        drop_cnt += int'(ba.drop);
        if (ba.osc_rst) begin
            if (orst_cnt > 0) begin
                if (cyc - orst_last < gap_min) gap_min = cyc - orst_last;
                if (cyc - orst_last > gap_max) gap_max = cyc - orst_last;
            end
            orst_last = cyc;
            orst_cnt++;
        end
    endtask

    // Every cycle: {full_tick,drop,osc_rst,state_check,phi_to_no,busy,timeout,iter,changed}.
    initial begin
        forever begin
            @(negedge sclk);
            if (exp_on) begin
                chk("outputs{ft,drop,orst,chk,phi,busy,to,iter,chg}",
                    64'({ba.full_tick, ba.drop, ba.osc_rst, ba.state_check, ba.phi_to_no,
                         ba.busy, ba.timeout, ba.iter_count, ba.changed_count}),
                    64'({e_ft, e_dr, e_or, e_sc, e_phi, e_busy, m_timeout,
                         IWA'(m_iter), CWA'(m_chg)}));
            end
        end
    end

    // One run on dut_a starting from an IDLE cycle. ab_at: LOAD cycle to abort
    // in; rst_it/rst_s: iteration/settle cycle to reset in; pulse_it: iteration
    // whose SETTLE sees a stray load pulse; w_*: hand-computed DONE values.
    task automatic do_run(input int ab_at, input int rst_it, input int rst_s,
                          input int pulse_it, input bit ack_load, input bit ack_abort,
                          input int w_iter, input logic w_to, input int w_chg);
        int            k;
        int            t0;
        logic [NO-1:0] v;
        ft_cnt = 0; drop_cnt = 0; orst_cnt = 0; orst_last = 0;
        gap_min = 1000000; gap_max = 0;
        set_exp(0, 0, 0, 0, 0, 0);
        ba.load = 1'b1;
        t0 = cyc;
        step();
        ba.load = 1'b0;
        for (int i = 1; i <= LC; i++) begin
            set_exp(1, 0, 0, 0, 0, 1);
            if (i == ab_at) begin
                ba.abort = 1'b1;
                step();
                ba.abort = 1'b0;
                m_timeout = 1'b0;
                set_exp(0, 0, 0, 0, 0, 0);
                chk("abort_load_full_tick", 64'(ba.full_tick), 64'd0);
                chk("abort_load_busy", 64'(ba.busy), 64'd0);
                return;
            end
            step();
        end
        m_iter = 0; m_stable = 0; m_timeout = 1'b0;
        set_exp(0, 1, 0, 0, 0, 1);
        step();
        k = 0;
        do begin
            k++;
            m_iter = k;
            set_exp(0, 0, 1, 0, 0, 1);
            step();
            for (int s = 1; s <= SC; s++) begin
                set_exp(0, 0, 0, 0, 0, 1);
                if (k == rst_it && s == rst_s) begin
                    #2 re_n = 1'b0;
                    m_timeout = 1'b0; m_iter = 0; m_chg = 0; m_stable = 0;
                    set_exp(0, 0, 0, 0, 0, 0);
                    #1 chk("async_reset_outputs",
                           64'({ba.full_tick, ba.drop, ba.osc_rst, ba.state_check,
                                ba.phi_to_no, ba.busy, ba.timeout, ba.iter_count,
                                ba.changed_count}), 64'd0);
                    step();
                    re_n = 1'b1;
                    return;
                end
                ba.load = (k == pulse_it) && (s == SC / 2);
                step();
            end
            ba.load = 1'b0;
            set_exp(0, 0, 0, 1, 0, 1);
            v = (k <= npat) ? pats[k-1] : '0;
            ba.state_changed = v;
            step();
            ba.state_changed = '0;
            m_chg = $countones(v);
            if (v != '0) m_stable = 0;
            else if (m_stable < SI) m_stable++;
        end while (m_stable != SI && k < MI);
        m_timeout = (m_stable != SI);
        set_exp(0, 0, 0, 0, 1, 0);
        chk("done_latency", 64'(cyc - t0), 64'(LC + w_iter * (SC + 2) + 2));
        chk("done_iter_count", 64'(ba.iter_count), 64'(w_iter));
        chk("done_timeout", 64'(ba.timeout), 64'(w_to));
        chk("done_changed_count", 64'(ba.changed_count), 64'(w_chg));
        for (int d = 0; d < 3; d++) begin
            set_exp(0, 0, 0, 0, 1, 0);
            step();
        end
        set_exp(0, 0, 0, 0, 1, 0);
        ba.done_ack = 1'b1;
        ba.load     = ack_load;
        ba.abort    = ack_abort;
        step();
        ba.done_ack = 1'b0;
        ba.abort    = 1'b0;
        if (ack_abort) m_timeout = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0);
        chk("after_ack_phi_to_no", 64'(ba.phi_to_no), 64'd0);
        chk("after_ack_no_load", 64'(ba.full_tick), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        int nck;
        ba.load = 1'b0; ba.abort = 1'b0; ba.done_ack = 1'b0; ba.state_changed = '0;
        bb.load = 1'b0; bb.abort = 1'b0; bb.done_ack = 1'b0; bb.state_changed = '0;
        ft_cnt = 0; drop_cnt = 0; orst_cnt = 0; orst_last = 0; gap_min = 0; gap_max = 0;
        for (int i = 0; i < 40; i++) pats[i] = '0;
        npat = 0;
        set_exp(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("reset_outputs_a",
            64'({ba.full_tick, ba.drop, ba.osc_rst, ba.state_check, ba.phi_to_no,
                 ba.busy, ba.timeout, ba.iter_count, ba.changed_count}), 64'd0);
        chk("reset_busy_b", 64'(bb.busy), 64'd0);
        re_n = 1'b1;
        step();

        // Convergence: 0x0005 on checks 1-3, then quiet; ack together with load.
        npat = 3;
        for (int i = 0; i < 3; i++) pats[i] = 15'h0005;
        do_run(0, 0, 0, 0, 1'b1, 1'b0, 5, 1'b0, 0);
        chk("conv_full_tick_cycles", 64'(ft_cnt), 64'd60);
        chk("conv_drop_cycles", 64'(drop_cnt), 64'd1);
        chk("conv_osc_rst_pulses", 64'(orst_cnt), 64'd5);
        chk("conv_osc_rst_gap_min", 64'(gap_min), 64'd19);
        chk("conv_osc_rst_gap_max", 64'(gap_max), 64'd19);

        // Timeout: every oscillator changes on every check; stray load in
        // SETTLE of iteration 2; leave DONE with abort and done_ack together.
        npat = 40;
        for (int i = 0; i < 40; i++) pats[i] = 15'h7FFF;
        do_run(0, 0, 0, 2, 1'b0, 1'b1, 32, 1'b1, 15);
        chk("abort_in_done_timeout", 64'(ba.timeout), 64'd0);
        chk("abort_in_done_busy", 64'(ba.busy), 64'd0);
        step();

        // Abort in LOAD cycle 30.
        do_run(30, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
        step();

        // Asynchronous reset in SETTLE cycle 8 of iteration 3.
        npat = 5;
        for (int i = 0; i < 5; i++) pats[i] = 15'h0001;
        do_run(0, 3, 8, 0, 1'b0, 1'b0, 0, 1'b0, 0);
        step();

        // Fresh run after reset: full load window, quiet array converges at check 2.
        npat = 0;
        do_run(0, 0, 0, 0, 1'b0, 1'b0, 2, 1'b0, 0);
        chk("post_reset_full_tick_cycles", 64'(ft_cnt), 64'd60);
        step();

        // Convergence and iteration limit on the same check (dut_b).
        bb.load = 1'b1;
        step();
        bb.load = 1'b0;
        steps = 1;
        nck = 0;
        while (!bb.phi_to_no && steps < 100) begin
            if (bb.state_check) begin
                bb.state_changed = (nck < 3) ? 15'h0003 : 15'h0000;
                nck++;
            end else begin
                bb.state_changed = '0;
            end
            step();
            steps++;
        end
        bb.state_changed = '0;
        chk("simul_reached_done", 64'(bb.phi_to_no), 64'd1);
        chk("simul_latency", 64'(steps), 64'd21);
        chk("simul_timeout", 64'(bb.timeout), 64'd0);
        chk("simul_iter_count", 64'(bb.iter_count), 64'd4);
        chk("simul_changed_count", 64'(bb.changed_count), 64'd0);
        bb.done_ack = 1'b1;
        step();
        bb.done_ack = 1'b0;
        chk("simul_ack_idle", 64'({bb.phi_to_no, bb.busy}), 64'd0);
        step();

        exp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
